// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared definitions for the clock core.
//                Contents: operation codes, the decoder state type, counter
//                limits and a wrap-around increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Held operation codes presented by the button encoder
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_SEC0  = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    // Operation decoder states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Counter limits (inclusive)
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // Increment a 6-bit counter, wrapping to 0 after max
    function automatic logic [5:0] inc_wrap6(input logic [5:0] value,
                                             input logic [5:0] max);
        return (value == max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_core_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Divides the system clock down to a one-cycle tick pulse.
//                The count runs 0..TICK_DIV-1 and tick is high while the
//                count sits at TICK_DIV-1.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                clear - synchronous restart of the count; masks tick
//                tick  - one-cycle pulse per TICK_DIV clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);
    // A clear in the same cycle throws the pending tick away
    assign tick    = at_last && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || at_last) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : clock_core
//  Description : Timekeeping core and operation decoder. Synchronizes the
//                held encoder op code, executes it once per press, drives
//                encoder_reset back to the encoder, and keeps the
//                sec/min(/hour) counters advanced by an internal 1 Hz tick.
//  Config      : CLOCK_CORE_HOUR_EN - when defined, a 0..23 hour counter
//                receives the minute carry; otherwise hour is tied to 0.
//  Ports       : clk           - system clock, rising edge
//                rst_n         - asynchronous active-low reset
//                operate[1:0]  - held op code (asynchronous to clk)
//                encoder_reset - registered request to clear operate
//                busy          - high while executing/acknowledging
//                sec[5:0]      - seconds 0..59
//                min[5:0]      - minutes 0..59
//                hour[4:0]     - hours 0..23 (0 without CLOCK_CORE_HOUR_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] operate,
    output logic       encoder_reset,
    output logic       busy,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour
);

    state_t     state;
    state_t     next_state;
    logic [1:0] op_meta;
    logic [1:0] op_s;
    logic [1:0] op_q;
    logic [1:0] op_r;
    logic       accept;
    logic       encoder_reset_next;
    logic       in_exec;
    logic       clear;
    logic       tick;
    logic       tick_pend;
    logic       advance;
    logic       sec_wrap;
    logic       min_wrap;

    // ------------------------------------------------------------------
    // Input synchronizer plus one stability stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_meta <= OP_NONE;
            op_s    <= OP_NONE;
            op_q    <= OP_NONE;
        end else begin
            op_meta <= operate;
            op_s    <= op_meta;
            op_q    <= op_s;
        end
    end

    // A code must be seen on two consecutive samples to count as a press
    assign accept = (op_s != OP_NONE) && (op_s == op_q);

    // ------------------------------------------------------------------
    // Decoder FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_r          <= OP_NONE;
            encoder_reset <= 1'b0;
        end else begin
            state         <= next_state;
            encoder_reset <= encoder_reset_next;
            if (state == ST_IDLE && accept) begin
                op_r <= op_s;
            end
        end
    end

    // Decoder FSM: next state. ACK ignores every nonzero code so a held
    // or changed code cannot execute a second time.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)            next_state = ST_EXEC;
            ST_EXEC:                        next_state = ST_ACK;
            ST_ACK:  if (op_s == OP_NONE)   next_state = ST_IDLE;
            default:                        next_state = ST_IDLE;
        endcase
    end

    // Decoder FSM: outputs. encoder_reset is registered from next_state so
    // it rises on ACK entry and falls on the return to IDLE.
    always_comb begin
        busy               = (state != ST_IDLE);
        encoder_reset_next = (next_state == ST_ACK);
    end

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    assign in_exec = (state == ST_EXEC);
    // Zeroing ops restart the divider and discard a coinciding tick
    assign clear   = in_exec && ((op_r == OP_SEC0) || (op_r == OP_RESET));

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    // A tick during a minute_add EXEC is replayed on the following cycle;
    // the divider has just wrapped, so no fresh tick can collide with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_pend <= 1'b0;
        end else begin
            tick_pend <= in_exec && (op_r == OP_MADD) && tick;
        end
    end

    assign advance  = tick_pend || (tick && !in_exec);
    assign sec_wrap = (sec == SEC_MAX);
    assign min_wrap = (min == MIN_MAX);

    // ------------------------------------------------------------------
    // Seconds and minutes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec <= 6'd0;
            min <= 6'd0;
        end else if (in_exec) begin
            case (op_r)
                OP_MADD:  min <= inc_wrap6(min, MIN_MAX);
                OP_SEC0:  sec <= 6'd0;
                OP_RESET: begin
                    sec <= 6'd0;
                    min <= 6'd0;
                end
                default: ;
            endcase
        end else if (advance) begin
            sec <= inc_wrap6(sec, SEC_MAX);
            if (sec_wrap) begin
                min <= inc_wrap6(min, MIN_MAX);
            end
        end
    end

    // ------------------------------------------------------------------
    // Hours (optional)
    // ------------------------------------------------------------------
`ifdef CLOCK_CORE_HOUR_EN
    logic [4:0] hour_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_cnt <= 5'd0;
        end else if (in_exec) begin
            if (op_r == OP_RESET) begin
                hour_cnt <= 5'd0;
            end
        end else if (advance && sec_wrap && min_wrap) begin
            hour_cnt <= (hour_cnt == HOUR_MAX) ? 5'd0 : hour_cnt + 5'd1;
        end
    end

    assign hour = hour_cnt;
`else
    assign hour = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_core
//  Description : Self-checking bench for clock_core with TICK_DIV=4.
//                A time-of-day model (seconds since midnight) predicts all
//                outputs each cycle; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_core;

    localparam int TD = 4;
`ifdef CLOCK_CORE_HOUR_EN
    localparam int TMOD = 86400;
    localparam int HOUR_EXP_AFTER_WRAP = 1;
`else
    localparam int TMOD = 3600;
    localparam int HOUR_EXP_AFTER_WRAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] operate = 2'b00;
    logic       encoder_reset;
    logic       busy;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;

    int checks = 0;
    int errors = 0;

    clock_core #(
        .TICK_DIV (TD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .operate       (operate),
        .encoder_reset (encoder_reset),
        .busy          (busy),
        .sec           (sec),
        .min           (min),
        .hour          (hour)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: time of day in seconds, divider phase, and the
    // press protocol (0 = waiting, 1 = executing, 2 = acknowledging).
    // ------------------------------------------------------------------
    int         m_t, m_div, m_phase;
    logic       m_pend;
    logic [1:0] m_s1, m_s2, m_s3, m_op;

    function automatic int apply_op(input int t, input logic [1:0] op);
        int mm;
        mm = (t / 60) % 60;
        case (op)
            2'b10:   return t - mm * 60 + ((mm + 1) % 60) * 60;
            2'b01:   return t - (t % 60);
            2'b11:   return 0;
            default: return t;
        endcase
    endfunction

    logic m_tick, m_exec, m_zeroing, m_adv, m_accept;
    assign m_tick    = (m_div == TD - 1);
    assign m_exec    = (m_phase == 1);
    assign m_zeroing = m_exec && (m_op == 2'b01 || m_op == 2'b11);
    assign m_adv     = m_pend || (m_tick && !m_exec);
    assign m_accept  = (m_phase == 0) && (m_s2 != 2'b00) && (m_s2 == m_s3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_div <= 0; m_phase <= 0; m_pend <= 1'b0;
            m_s1 <= 2'b00; m_s2 <= 2'b00; m_s3 <= 2'b00; m_op <= 2'b00;
        end else begin
            m_t    <= m_exec ? apply_op(m_t, m_op) : (m_adv ? (m_t + 1) % TMOD : m_t);
            m_div  <= m_zeroing ? 0 : (m_div + 1) % TD;
            m_pend <= m_exec && (m_op == 2'b10) && m_tick;
            if (m_accept) begin
                m_phase <= 1;
                m_op    <= m_s2;
            end else if (m_exec) begin
                m_phase <= 2;
            end else if (m_phase == 2 && m_s2 == 2'b00) begin
                m_phase <= 0;
            end
            m_s1 <= operate; m_s2 <= m_s1; m_s3 <= m_s2;
        end
    end

    function automatic int m_sec();  return m_t % 60;        endfunction
    function automatic int m_min();  return (m_t / 60) % 60; endfunction
    function automatic int m_hour(); return m_t / 3600;      endfunction

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (sec != 6'(m_sec()) || min != 6'(m_min()) || hour != 5'(m_hour()) ||
                busy != (m_phase != 0) || encoder_reset != (m_phase == 2)) begin
                errors++;
                $display("FAIL model t=%0t: got %0d:%0d:%0d busy=%0b er=%0b expected %0d:%0d:%0d busy=%0b er=%0b",
                         $time, hour, min, sec, busy, encoder_reset,
                         m_hour(), m_min(), m_sec(), m_phase != 0, m_phase == 2);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full press/release, paced by the model's protocol phase
    task automatic press(input logic [1:0] code);
        int i;
        operate = code;
        for (i = 0; i < 12 && m_phase != 2; i++) @(negedge clk);
        check("press_ack_timeout", m_phase, 2);
        operate = 2'b00;
        for (i = 0; i < 12 && m_phase != 0; i++) @(negedge clk);
        check("press_release_timeout", m_phase, 0);
        step(1);
    endtask

    task automatic press_until_min(input int target);
        int n;
        for (n = 0; n < 130 && m_min() != target; n++) press(2'b10);
        check("reach_min", m_min(), target);
    endtask

    task automatic wait_sec_div(input int s, input int d);
        int i;
        for (i = 0; i < 600 && !(m_sec() == s && m_div == d); i++) @(negedge clk);
        check("wait_sec_div", m_sec() * 10 + m_div, s * 10 + d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        step(2);
        check("reset_sec", sec, 0);
        check("reset_er", encoder_reset, 0);
        rst_n = 1'b1;

        // First tick four clocks after reset release
        step(3);
        check("pre_first_tick_sec", sec, 0);
        step(1);
        check("first_tick_sec", sec, 1);
        step(64);
        check("sec_17", sec, 17);

        // Asynchronous reset mid-count
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sec", sec, 0);
        check("async_rst_min", min, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;

        // Free run: 240 clocks = 60 ticks
        step(240);
        check("freerun_min", min, 1);
        check("freerun_sec", sec, 0);

        // minute_add at 59 with a 20-cycle hold
        press_until_min(59);
        press(2'b01);
        wait_sec_div(30, 0);
        check("madd_pre_min", min, 59);
        operate = 2'b10;
        step(4);
        check("madd_exec_busy", busy, 1);
        check("madd_exec_er", encoder_reset, 0);
        step(1);
        check("madd_ack_er", encoder_reset, 1);
        check("madd_wrap_min", min, 0);
        step(15);
        operate = 2'b00;
        step(2);
        check("madd_er_held", encoder_reset, 1);
        step(1);
        check("madd_er_released", encoder_reset, 0);
        check("madd_busy_released", busy, 0);
        check("madd_single_inc", min, 0);

        // sec_to_zero with the tick landing in EXEC
        wait_sec_div(44, 3);
        operate = 2'b01;
        step(4);
        check("sec0_exec_sec", sec, 45);
        step(1);
        check("sec0_zeroed", sec, 0);
        operate = 2'b00;
        step(3);
        check("sec0_tick_dropped", sec, 0);
        step(1);
        check("sec0_next_tick", sec, 1);

        // minute_add with a deferred tick
        press_until_min(5);
        press(2'b01);
        wait_sec_div(9, 3);
        operate = 2'b10;
        step(4);
        check("defer_exec_sec", sec, 10);
        check("defer_exec_min", min, 5);
        step(1);
        check("defer_min", min, 6);
        check("defer_sec_held", sec, 10);
        step(1);
        check("defer_sec_applied", sec, 11);
        operate = 2'b00;
        step(4);

        // reset code, then a changed code while still in ACK
        press_until_min(34);
        operate = 2'b11;
        step(5);
        check("rstcode_sec", sec, 0);
        check("rstcode_min", min, 0);
        check("rstcode_hour", hour, 0);
        operate = 2'b10;
        step(10);
        check("ack_ignores_er", encoder_reset, 1);
        check("ack_ignores_min", min, 0);
        operate = 2'b00;
        step(7);
        check("no_madd_after_switch", min, 0);
        check("idle_after_switch", busy, 0);

        // Asynchronous reset in the middle of ACK
        operate = 2'b11;
        step(6);
        check("midack_er_high", encoder_reset, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midack_rst_er", encoder_reset, 0);
        check("midack_rst_busy", busy, 0);
        operate = 2'b00;
        @(negedge clk) rst_n = 1'b1;

        // Minute wrap by tick: carry into hour only when present
        press_until_min(59);
        press(2'b01);
        wait_sec_div(59, 3);
        check("prewrap_hour", hour, 0);
        step(1);
        check("wrap_sec", sec, 0);
        check("wrap_min", min, 0);
        check("wrap_hour", hour, HOUR_EXP_AFTER_WRAP);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
